// File: rtl/bcd_to_binary_serial_pkg.sv
// Shared definitions for the serial BCD-to-binary converter.
//   state_t        : FSM encoding (IDLE / SHIFT / DONE)
//   BCD_MAX_DIGIT  : largest legal BCD digit value
//   DD_ADJ_THRESH  : nibble value at or above which the reverse double-dabble adjusts
//   DD_ADJ         : amount subtracted from an adjusted nibble
//   bin_width()    : binary result width needed for a given number of BCD digits
package bcd_to_binary_serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int BCD_MAX_DIGIT = 9;
   localparam int DD_ADJ_THRESH = 8;
   localparam int DD_ADJ        = 3;

   // ceil(log2(10**nd)): bits needed to hold 10**nd - 1
   function automatic int bin_width(input int nd);
      return $clog2(10 ** nd);
   endfunction

endpackage

// File: rtl/bcd_to_binary_serial_nibble_adjust.sv
// One-nibble correction step of the reverse double-dabble.
//   nib_in  : 4-bit nibble after the right shift
//   nib_out : nib_in - 3 when nib_in >= 8, else nib_in
// A nibble >= 8 after the shift means a former tens-weight bit (worth 10/2 = 5)
// landed in bit 3 (worth 8); subtracting 3 restores the decimal weight.
module bcd_nibble_adjust
   import bcd_to_binary_serial_pkg::*;
(
   input  logic [3:0] nib_in,
   output logic [3:0] nib_out
);

   assign nib_out = (nib_in >= 4'(DD_ADJ_THRESH)) ? (nib_in - 4'(DD_ADJ)) : nib_in;

endmodule

// File: rtl/bcd_to_binary_serial.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one bit per clock).
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset
//   start    : conversion request, honoured only when idle and not presenting done
//   bcd_in   : packed BCD digits, digit 0 in [3:0]; captured with start
//   busy     : high while iterations are running
//   done     : one-cycle pulse, bin_out/err valid
//   err      : input contained a digit > 9 (held until the next accepted start)
//   bin_out  : binary result, held until replaced by the next conversion
module bcd_to_binary_serial
   import bcd_to_binary_serial_pkg::*;
#(
   parameter int NDIGITS = 2,
   parameter int BIN_W   = bin_width(NDIGITS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [4*NDIGITS-1:0] bcd_in,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [BIN_W-1:0]     bin_out
);

   localparam int BCD_W = 4 * NDIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   state_t           state;
   logic [BCD_W-1:0] bcd_q;
   logic [BCD_W-1:0] bcd_sh;
   logic [BCD_W-1:0] bcd_adj;
   logic [BIN_W-1:0] bin_q;
   logic [BIN_W-1:0] bin_sh;
   logic [CNT_W-1:0] cnt;
   logic             in_bad;

   // {bcd, bin} shifted right as one register: bcd LSB falls into bin MSB
   assign bcd_sh = bcd_q >> 1;
   assign bin_sh = {bcd_q[0], bin_q[BIN_W-1:1]};

   for (genvar g = 0; g < NDIGITS; g++) begin : g_adj
      bcd_nibble_adjust u_adj (
         .nib_in  (bcd_sh[4*g +: 4]),
         .nib_out (bcd_adj[4*g +: 4])
      );
   end

   always_comb begin
      in_bad = 1'b0;
      for (int i = 0; i < NDIGITS; i++)
         if (bcd_in[4*i +: 4] > 4'(BCD_MAX_DIGIT)) in_bad = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         bin_out <= '0;
         bcd_q   <= '0;
         bin_q   <= '0;
         cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               // done is registered one cycle after DONE, so the FSM is already
               // back in IDLE while it is high; gate start so it is ignored then.
               if (start && !done) begin
                  if (in_bad) begin
                     err     <= 1'b1;
                     bin_out <= '0;
                     state   <= ST_DONE;
                  end else begin
                     err   <= 1'b0;
                     bcd_q <= bcd_in;
                     bin_q <= '0;
                     cnt   <= '0;
                     busy  <= 1'b1;
                     state <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               bcd_q <= bcd_adj;
               bin_q <= bin_sh;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(BIN_W - 1)) begin
                  busy  <= 1'b0;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               done <= 1'b1;
               // an error result was already forced to zero at start
               if (!err) bin_out <= bin_q;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_binary_serial.sv
// Scoreboard bench for bcd_to_binary_serial (2 digits, 7-bit result).
// The driver pushes the expected result computed from decimal digit weights;
// the monitor pops and compares whenever done is seen.
module tb_bcd_to_binary_serial;

   localparam int ND = 2;
   localparam int BW = 7;

   typedef struct {
      logic [BW-1:0] bin;
      logic          err;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [7:0]    bcd_in;
   logic          busy;
   logic          done;
   logic          err;
   logic [BW-1:0] bin_out;

   int   checks = 0;
   int   errors = 0;
   int   ndone  = 0;
   logic prev_done = 1'b0;
   exp_t sb[$];

   bcd_to_binary_serial #(.NDIGITS(ND), .BIN_W(BW)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .bin_out (bin_out)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [7:0] b);
      exp_t e;
      int   v;
      int   d;
      v     = 0;
      e.err = 1'b0;
      for (int i = 0; i < ND; i++) begin
         d = int'((b >> (4 * i)) & 8'hF);
         if (d > 9) e.err = 1'b1;
         v += d * (10 ** i);
      end
      e.bin = e.err ? '0 : BW'(v);
      return e;
   endfunction

   // monitor
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!reset) begin
         if (prev_done) begin
            checks++;
            if (done) begin
               errors++;
               $display("FAIL done_pulse: done high %0d cycles, required 1", 2);
            end
         end
         if (done) begin
            ndone++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: bin_out=%0d err=%0b with no pending request", bin_out, err);
            end else begin
               e = sb.pop_front();
               if (bin_out !== e.bin || err !== e.err) begin
                  errors++;
                  $display("FAIL result: bin_out=%0d err=%0b, required bin_out=%0d err=%0b",
                           bin_out, err, e.bin, e.err);
               end
            end
         end
      end
      prev_done = done;
   end

   task automatic run(input logic [7:0] b, input int glitch);
      exp_t e;
      int   n;
      int   bc;
      e = model(b);
      @(negedge clk);
      start  = 1'b1;
      bcd_in = b;
      sb.push_back(e);
      @(posedge clk);
      #1;
      start  = 1'b0;
      bcd_in = 8'($urandom);
      bc = busy ? 1 : 0;
      n  = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         start = (glitch > 0 && n == glitch);
         if (start) bcd_in = 8'h88;
         @(posedge clk);
         #1;
         n++;
         if (busy) bc++;
      end
      start = 1'b0;
      checks++;
      if (n != (e.err ? 1 : BW + 1)) begin
         errors++;
         $display("FAIL latency bcd=%h: done after %0d edges, required %0d", b, n, e.err ? 1 : BW + 1);
      end
      checks++;
      if (bc != (e.err ? 0 : BW)) begin
         errors++;
         $display("FAIL busy_len bcd=%h: busy %0d cycles, required %0d", b, bc, e.err ? 0 : BW);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int codes[100];
      int t;
      int j;
      int nd0;
      reset  = 1'b1;
      start  = 1'b0;
      bcd_in = 8'h00;
      #2;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bin_out !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b err=%b bin_out=%0d, required all 0", busy, done, err, bin_out);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      run(8'h00, 0);
      run(8'h31, 0);
      run(8'h99, 0);
      run(8'h47, 0);
      run(8'hA5, 0);
      run(8'h0F, 0);

      // start mid-conversion must be ignored
      nd0 = ndone;
      run(8'h12, 3);
      checks++;
      if (ndone - nd0 != 1) begin
         errors++;
         $display("FAIL single_done: %0d done pulses, required 1", ndone - nd0);
      end

      // reset between edges mid-conversion
      @(negedge clk);
      start  = 1'b1;
      bcd_in = 8'h64;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bin_out !== '0) begin
         errors++;
         $display("FAIL reset_abort: busy=%b done=%b err=%b bin_out=%0d, required all 0", busy, done, err, bin_out);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      nd0 = ndone;
      repeat (12) @(posedge clk);
      #2;
      checks++;
      if (ndone != nd0) begin
         errors++;
         $display("FAIL aborted_done: %0d done pulses after abort, required 0", ndone - nd0);
      end
      run(8'h64, 0);

      // every valid code in random order
      for (int i = 0; i < 100; i++) codes[i] = i;
      for (int i = 99; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         t = codes[i];
         codes[i] = codes[j];
         codes[j] = t;
      end
      for (int i = 0; i < 100; i++)
         run({4'(codes[i] / 10), 4'(codes[i] % 10)}, 0);

      // arbitrary bytes, mostly invalid
      for (int i = 0; i < 20; i++)
         run(8'($urandom), 0);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results never produced, required 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
